// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: MIPS opcode/funct encodings and the
// decoded hazard view of a decode-stage instruction.
package hazard_scoreboard_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0a,
        OP_SLTIU = 6'h0b,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_XORI  = 6'h0e,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_JR   = 6'h08,
        F_ADD  = 6'h20,
        F_ADDU = 6'h21,
        F_SUB  = 6'h22,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2a,
        F_SLTU = 6'h2b
    } funct_t;

    typedef enum logic {
        HZ_ALU    = 1'b0,
        HZ_BRANCH = 1'b1
    } hz_class_t;

    typedef struct packed {
        regbits_t  src0;
        regbits_t  src1;
        logic      use0;
        logic      use1;
        regbits_t  dest;
        logic      wen;
        logic      is_load;
        hz_class_t cls;
    } hz_decode_t;

    localparam regbits_t REG_RA = 5'd31;

    // I-type ALU ops read rs and write rt; LUI is excluded because it reads nothing.
    function automatic logic is_itype_alu(input opcode_t op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Control bundle between the datapath (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if;
    import hazard_scoreboard_pkg::*;

    logic        ihit;
    logic        dhit;
    logic        mem_dREN;
    logic        mem_dWEN;
    logic [31:0] dec_instr;
    logic        dec_valid;
    logic        ex_redirect;

    logic        pcEN;
    logic        fdEN;
    logic        fd_flush;
    logic        dxEN;
    logic        dx_flush;
    logic        xmEN;
    logic        mwEN;
    logic        hz_stall;
    logic [31:0] stall_cycles;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, dec_instr, dec_valid, ex_redirect,
        input  pcEN, fdEN, fd_flush, dxEN, dx_flush, xmEN, mwEN, hz_stall, stall_cycles
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, dec_instr, dec_valid, ex_redirect,
        output pcEN, fdEN, fd_flush, dxEN, dx_flush, xmEN, mwEN, hz_stall, stall_cycles
    );

endinterface

// File: rtl/hazard_decode.sv
// Combinational classifier: which registers the decode instruction reads and
// writes, and whether it compares in decode (branch class) or in EX.
module hazard_decode
    import hazard_scoreboard_pkg::*;
(
    input  logic [31:0] instr,
    output hz_decode_t  dec
);

    opcode_t  op;
    regbits_t rs, rt, rd;
    logic     is_jr;
    logic     unused_bits;

    assign op          = opcode_t'(instr[31:26]);
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign is_jr       = (instr[5:0] == F_JR);
    assign unused_bits = ^instr[10:6];

    always_comb begin
        dec.src0    = rs;
        dec.src1    = rt;
        dec.use0    = 1'b0;
        dec.use1    = 1'b0;
        dec.dest    = '0;
        dec.wen     = 1'b0;
        dec.is_load = 1'b0;
        dec.cls     = HZ_ALU;
        case (op)
            OP_RTYPE: begin
                dec.use0 = 1'b1;
                if (is_jr) begin
                    dec.cls = HZ_BRANCH;
                end else begin
                    dec.use1 = 1'b1;
                    dec.dest = rd;
                    dec.wen  = 1'b1;
                end
            end
            OP_LW: begin
                dec.use0    = 1'b1;
                dec.dest    = rt;
                dec.wen     = 1'b1;
                dec.is_load = 1'b1;
            end
            OP_LUI: begin
                dec.dest = rt;
                dec.wen  = 1'b1;
            end
            OP_SW: begin
                dec.use0 = 1'b1;
                dec.use1 = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.use0 = 1'b1;
                dec.use1 = 1'b1;
                dec.cls  = HZ_BRANCH;
            end
            OP_JAL: begin
                dec.dest = REG_RA;
                dec.wen  = 1'b1;
            end
            default: begin
                if (is_itype_alu(op)) begin
                    dec.use0 = 1'b1;
                    dec.dest = rt;
                    dec.wen  = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard driving pipeline enables/flushes for the
// 5-stage MIPS pipeline; a nonzero count means a write is still in flight.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int BR_LAT   = 1,
    parameter int NREGS    = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    hazard_scoreboard_if.slave  bus
);

    localparam int CW_RAW = $clog2(LOAD_LAT + BR_LAT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] BR_CNT = CW'(BR_LAT);
    localparam logic [CW-1:0] LD_CNT = CW'(LOAD_LAT + BR_LAT);

    hz_decode_t      dec;
    logic [CW-1:0]   count [NREGS];
    logic [CW-1:0]   cnt0, cnt1;
    logic            busy0, busy1, hazard, memstall, issue;
    logic [31:0]     stall_cnt;

    hazard_decode u_decode (
        .instr (bus.dec_instr),
        .dec   (dec)
    );

    always_comb begin
        cnt0 = '0;
        cnt1 = '0;
        if (int'(dec.src0) < NREGS) cnt0 = count[dec.src0];
        if (int'(dec.src1) < NREGS) cnt1 = count[dec.src1];
    end

    // Branches compare in decode so any in-flight write blocks them; ALU
    // consumers can take a forwarded value once only BR_LAT slack remains.
    always_comb begin
        busy0 = 1'b0;
        busy1 = 1'b0;
        if (dec.use0 && dec.src0 != '0)
            busy0 = (dec.cls == HZ_BRANCH) ? (cnt0 != '0) : (cnt0 > BR_CNT);
        if (dec.use1 && dec.src1 != '0)
            busy1 = (dec.cls == HZ_BRANCH) ? (cnt1 != '0) : (cnt1 > BR_CNT);
    end

    assign hazard   = bus.dec_valid & (busy0 | busy1);
    assign memstall = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;

    always_comb begin
        bus.pcEN     = bus.ihit;
        bus.fdEN     = 1'b1;
        bus.fd_flush = 1'b0;
        bus.dxEN     = 1'b1;
        bus.dx_flush = 1'b0;
        bus.xmEN     = 1'b1;
        bus.mwEN     = 1'b1;
        bus.hz_stall = 1'b0;
        issue        = 1'b0;
        if (memstall) begin
            bus.pcEN = 1'b0;
            bus.fdEN = 1'b0;
            bus.dxEN = 1'b0;
            bus.xmEN = 1'b0;
            bus.mwEN = 1'b0;
        end else if (bus.ex_redirect) begin
            bus.pcEN     = 1'b1;
            bus.fd_flush = 1'b1;
            bus.dx_flush = 1'b1;
        end else if (hazard) begin
            bus.pcEN     = 1'b0;
            bus.fdEN     = 1'b0;
            bus.dx_flush = 1'b1;
            bus.hz_stall = 1'b1;
        end else begin
            issue = bus.dec_valid;
            if (!bus.ihit) begin
                bus.pcEN     = 1'b0;
                bus.fd_flush = 1'b1;
            end
        end
    end

    // Bubbles advancing during stalls/redirects still age the counters; only
    // a frozen memory stage holds them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) count[r] <= '0;
            stall_cnt <= '0;
        end else begin
            if (!memstall) begin
                for (int r = 0; r < NREGS; r++) begin
                    if (r == 0)
                        count[r] <= '0;
                    else if (issue && dec.wen && dec.dest == regbits_t'(r))
                        count[r] <= dec.is_load ? LD_CNT : BR_CNT;
                    else if (count[r] != '0)
                        count[r] <= count[r] - CW'(1);
                end
            end
            if (bus.hz_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with LOAD_LAT=1, BR_LAT=1.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    // {pcEN, fdEN, fd_flush, dxEN, dx_flush, xmEN, mwEN, hz_stall}
    localparam logic [7:0] O_RUN   = 8'b1101_0110;
    localparam logic [7:0] O_STALL = 8'b0001_1111;
    localparam logic [7:0] O_MEM   = 8'b0000_0000;
    localparam logic [7:0] O_REDIR = 8'b1111_1110;
    localparam logic [7:0] O_NOIH  = 8'b0111_0110;

    logic clk;
    logic nrst;
    int   n_vec;
    int   n_err;
    logic [7:0] outs;

    hazard_scoreboard_if hz_bus ();

    hazard_scoreboard #(.LOAD_LAT(1), .BR_LAT(1), .NREGS(32)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (hz_bus)
    );

    assign outs = {hz_bus.pcEN, hz_bus.fdEN, hz_bus.fd_flush, hz_bus.dxEN,
                   hz_bus.dx_flush, hz_bus.xmEN, hz_bus.mwEN, hz_bus.hz_stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input regbits_t rs, input regbits_t rt,
                                          input regbits_t rd, input funct_t fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input opcode_t op, input regbits_t rs,
                                          input regbits_t rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [31:0] ins, input logic v,
                       input logic [7:0] exp);
        hz_bus.dec_instr = ins;
        hz_bus.dec_valid = v;
        @(negedge clk);
        chk(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle2();
        cyc("idle_a", 32'd0, 1'b0, O_RUN);
        cyc("idle_b", 32'd0, 1'b0, O_RUN);
    endtask

    logic [31:0] lw8, add981, beq80, addi9, bne92, sub399, lw9_8, beq90;
    logic [31:0] addu088, beq00, jal, beq31;

    initial begin
        n_vec = 0;
        n_err = 0;
        lw8     = itype(OP_LW,   5'd0,  5'd8, 16'h0004);
        add981  = rtype(5'd8, 5'd1, 5'd9, F_ADD);
        beq80   = itype(OP_BEQ,  5'd8,  5'd0, 16'h0003);
        addi9   = itype(OP_ADDI, 5'd0,  5'd9, 16'h0005);
        bne92   = itype(OP_BNE,  5'd9,  5'd2, 16'h0002);
        sub399  = rtype(5'd9, 5'd9, 5'd3, F_SUB);
        lw9_8   = itype(OP_LW,   5'd8,  5'd9, 16'h0000);
        beq90   = itype(OP_BEQ,  5'd9,  5'd0, 16'h0001);
        addu088 = rtype(5'd8, 5'd8, 5'd0, F_ADDU);
        beq00   = itype(OP_BEQ,  5'd0,  5'd0, 16'h0001);
        jal     = {6'h03, 26'h0000010};
        beq31   = itype(OP_BEQ,  5'd31, 5'd0, 16'h0001);

        nrst               = 1'b0;
        hz_bus.ihit        = 1'b1;
        hz_bus.dhit        = 1'b1;
        hz_bus.mem_dREN    = 1'b0;
        hz_bus.mem_dWEN    = 1'b0;
        hz_bus.dec_instr   = 32'd0;
        hz_bus.dec_valid   = 1'b0;
        hz_bus.ex_redirect = 1'b0;
        #12;
        chk("rst_outs", {24'd0, outs}, {24'd0, O_RUN});
        chk("rst_sc", hz_bus.stall_cycles, 32'd0);
        hz_bus.ihit = 1'b0;
        #1;
        chk("rst_noihit", {24'd0, outs}, {24'd0, O_NOIH});
        hz_bus.ihit = 1'b1;
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // load-use into ALU consumer: one stall
        cyc("t1_lw", lw8, 1'b1, O_RUN);
        cyc("t1_add_stall", add981, 1'b1, O_STALL);
        cyc("t1_add_issue", add981, 1'b1, O_RUN);
        chk("t1_sc", hz_bus.stall_cycles, 32'd1);
        idle2();

        // load-use into branch: two stalls
        cyc("t2_lw", lw8, 1'b1, O_RUN);
        cyc("t2_beq_s1", beq80, 1'b1, O_STALL);
        cyc("t2_beq_s2", beq80, 1'b1, O_STALL);
        cyc("t2_beq_issue", beq80, 1'b1, O_RUN);
        chk("t2_sc", hz_bus.stall_cycles, 32'd3);
        idle2();

        // ALU producer: branch stalls once, ALU consumer never
        cyc("t3_addi", addi9, 1'b1, O_RUN);
        cyc("t3_bne_stall", bne92, 1'b1, O_STALL);
        cyc("t3_bne_issue", bne92, 1'b1, O_RUN);
        cyc("t3_addi_b", addi9, 1'b1, O_RUN);
        cyc("t3_sub", sub399, 1'b1, O_RUN);
        chk("t3_sc", hz_bus.stall_cycles, 32'd4);
        idle2();

        // memory stall freezes the scoreboard
        cyc("t4_lw", lw8, 1'b1, O_RUN);
        hz_bus.dhit = 1'b0;
        hz_bus.mem_dREN = 1'b1;
        cyc("t4_mem1", add981, 1'b1, O_MEM);
        cyc("t4_mem2", add981, 1'b1, O_MEM);
        hz_bus.mem_dREN = 1'b0;
        hz_bus.mem_dWEN = 1'b1;
        cyc("t4_mem3", add981, 1'b1, O_MEM);
        chk("t4_sc_frozen", hz_bus.stall_cycles, 32'd4);
        hz_bus.mem_dWEN = 1'b0;
        hz_bus.dhit = 1'b1;
        cyc("t4_stall", add981, 1'b1, O_STALL);
        cyc("t4_issue", add981, 1'b1, O_RUN);
        chk("t4_sc", hz_bus.stall_cycles, 32'd5);
        idle2();

        // instruction miss: load still issues and its hazard follows
        hz_bus.ihit = 1'b0;
        cyc("t5_lw_noihit", lw8, 1'b1, O_NOIH);
        hz_bus.ihit = 1'b1;
        cyc("t5_add_stall", add981, 1'b1, O_STALL);
        cyc("t5_add_issue", add981, 1'b1, O_RUN);
        chk("t5_sc", hz_bus.stall_cycles, 32'd6);
        idle2();

        // redirect overrides a hazard; flushed LW $9 must not mark $9
        cyc("t6_lw", lw8, 1'b1, O_RUN);
        hz_bus.ex_redirect = 1'b1;
        cyc("t6_redirect", lw9_8, 1'b1, O_REDIR);
        hz_bus.ex_redirect = 1'b0;
        cyc("t6_beq9_free", beq90, 1'b1, O_RUN);
        chk("t6_sc", hz_bus.stall_cycles, 32'd6);

        // $0 never tracked, JAL marks $31, then async reset mid-stall
        cyc("t7_addu0", addu088, 1'b1, O_RUN);
        cyc("t7_beq00", beq00, 1'b1, O_RUN);
        cyc("t7_jal", jal, 1'b1, O_RUN);
        hz_bus.dec_instr = beq31;
        hz_bus.dec_valid = 1'b1;
        @(negedge clk);
        chk("t7_beq31_stall", {24'd0, outs}, {24'd0, O_STALL});
        #1;
        nrst = 1'b0;
        #1;
        chk("t7_rst_outs", {24'd0, outs}, {24'd0, O_RUN});
        chk("t7_rst_sc", hz_bus.stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        cyc("t7_after_rst", beq31, 1'b1, O_RUN);
        chk("t7_sc_final", hz_bus.stall_cycles, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
